// File: rtl/amstrad_vram_sched.sv
// amstrad_vram_sched: shares one 8-bit RAM port between video fetch (ph0/ph1) and Z80 (ph2).
// Define AMSTRAD_TURBO_SLOT_EN to also give ph3 to the CPU.
module amstrad_vram_sched #(
  parameter bit FETCH_WHEN_BLANK = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE_4,
  output logic        cyc1MHz,
  input  logic [13:0] crtc_ma,
  input  logic [4:0]  crtc_ra,
  input  logic        crtc_de,
  output logic [15:0] vram_D,
  output logic        vram_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic        cpu_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        mem_overrun
);
  typedef enum logic [1:0] {S_IDLE, S_VID, S_CPU} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_ph, w_nph;
  logic [14:0] r_vbase, w_base;
  logic [15:0] r_maddr, r_ca, r_vram;
  logic [7:0]  r_mwd, r_cd, r_even, r_odd, r_din, w_even, w_odd;
  logic        r_mwe, r_cwe, r_vb, r_valid, r_pend, r_gnt, r_ack, r_wait, r_ovr;
  logic        w_busy, w_ack, w_vid_ack, w_cpu_done, w_live, w_grant, w_set, w_cancel;
  logic        w_vid_slot, w_cpu_slot, w_to_ph2, w_unused;
  assign w_unused   = ^{crtc_ma[11:10], crtc_ra[4:3]};
  assign w_nph      = r_ph + 2'd1;
  assign w_base     = {crtc_ma[13:12], crtc_ra[2:0], crtc_ma[9:0]};
  assign w_busy     = r_state != S_IDLE;
  assign w_ack      = w_busy & mem_ack;
  assign w_vid_ack  = w_ack & (r_state == S_VID);
  assign w_cpu_done = w_ack & (r_state == S_CPU);
  assign w_vid_slot = CE_4 & ~w_nph[1] & (FETCH_WHEN_BLANK | crtc_de);
  assign w_to_ph2   = CE_4 & (w_nph == 2'd2);
`ifdef AMSTRAD_TURBO_SLOT_EN
  assign w_cpu_slot = CE_4 & w_nph[1];
`else
  assign w_cpu_slot = w_to_ph2;
`endif
  // A granted access completing on this edge must not be re-issued by a coinciding slot start.
  assign w_live     = r_gnt ? ~w_cpu_done : cpu_req & ~r_ack;
  assign w_grant    = w_cpu_slot & w_live;
  assign w_set      = cpu_req & ~r_pend & ~r_ack;
  assign w_cancel   = r_pend & ~r_gnt & ~cpu_req;
  assign w_even     = (w_vid_ack & ~r_vb) ? mem_rdata : r_even;
  assign w_odd      = (w_vid_ack & r_vb) ? mem_rdata : r_odd;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = CE_4 ? (w_vid_slot ? S_VID : w_grant ? S_CPU : S_IDLE) : w_ack ? S_IDLE : r_state;
  always_comb begin
    mem_req = r_state != S_IDLE;
    mem_we  = (r_state == S_CPU) & r_mwe;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ph    <= '0;
      r_vbase <= '0;
      r_maddr <= '0;
      r_mwe   <= 1'b0;
      r_mwd   <= '0;
      r_vb    <= 1'b0;
      r_even  <= '0;
      r_odd   <= '0;
      r_vram  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (CE_4) r_ph <= w_nph;
      if (CE_4 && w_nph == 2'd0) r_vbase <= w_base;
      if (w_vid_slot) begin
        r_maddr <= {w_nph[0] ? r_vbase : w_base, w_nph[0]};
        r_mwe   <= 1'b0;
        r_vb    <= w_nph[0];
      end else if (w_grant) begin
        r_maddr <= r_pend ? r_ca : cpu_addr;
        r_mwe   <= r_pend ? r_cwe : cpu_we;
        r_mwd   <= r_pend ? r_cd : cpu_dout;
      end
      r_even  <= w_even;
      r_odd   <= w_odd;
      if (w_to_ph2) r_vram <= {w_odd, w_even};
      r_valid <= w_to_ph2;
      r_ovr   <= r_ovr | (CE_4 & w_busy & ~mem_ack);
    end
  end
  // An abandoned CPU access keeps r_pend/r_gnt so the next CPU slot retries it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ca   <= '0;
      r_cwe  <= 1'b0;
      r_cd   <= '0;
      r_pend <= 1'b0;
      r_gnt  <= 1'b0;
      r_ack  <= 1'b0;
      r_din  <= '0;
      r_wait <= 1'b0;
    end else begin
      if (w_set) begin
        r_ca  <= cpu_addr;
        r_cwe <= cpu_we;
        r_cd  <= cpu_dout;
      end
      r_pend <= w_cpu_done ? 1'b0 : w_set ? 1'b1 : w_cancel ? 1'b0 : r_pend;
      r_gnt  <= w_cpu_done ? 1'b0 : w_grant ? 1'b1 : r_gnt;
      r_ack  <= w_cpu_done;
      if (w_cpu_done && !r_mwe) r_din <= mem_rdata;
      r_wait <= w_set ? 1'b1 : (r_ack | w_cancel) ? 1'b0 : r_wait;
    end
  end
  assign cyc1MHz     = (r_ph == 2'd0) & ~RESET;
  assign vram_D      = r_vram;
  assign vram_valid  = r_valid;
  assign cpu_din     = r_din;
  assign cpu_ack     = r_ack;
  assign cpu_wait    = r_wait;
  assign mem_addr    = r_maddr;
  assign mem_wdata   = r_mwd;
  assign mem_overrun = r_ovr;
endmodule

// File: tb/tb_amstrad_vram_sched.sv
// tb_amstrad_vram_sched: directed checks of video fetch, CPU slots, blank skip, overrun, turbo and reset.
`timescale 1ns/1ps
module tb_amstrad_vram_sched;
`ifdef AMSTRAD_TURBO_SLOT_EN
  localparam int RETRY_PH = 3, T2_PH = 3, T2_DUS = 0;
`else
  localparam int RETRY_PH = 2, T2_PH = 2, T2_DUS = 1;
`endif
  logic        CLK = 1'b0, RESET = 1'b1, CE_4 = 1'b0;
  logic [13:0] crtc_ma = '0;
  logic [4:0]  crtc_ra = '0;
  logic        crtc_de = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        cyc1MHz, vram_valid, cpu_ack, cpu_wait, mem_req, mem_we, mem_overrun;
  logic [15:0] vram_D, mem_addr;
  logic [7:0]  cpu_din, mem_wdata;
  logic        b_cyc, b_valid, b_cack, b_wait, b_req, b_we, b_ovr;
  logic [15:0] b_vram, b_addr;
  logic [7:0]  b_din, b_wd;
  logic [7:0]  b_rdata = '0;
  logic        b_ack = 1'b0;
  logic [7:0]  mem [0:65535];
  int          n_vec = 0, n_bad = 0, cnt = 0, bcnt = 0, wr_n = 0, ce_n = 0;
  bit          hold = 1'b0, ce_edge = 1'b0, last_we = 1'b0;
  logic [15:0] last_addr = '0;

  amstrad_vram_sched u_dut (
    .CLK(CLK), .RESET(RESET), .CE_4(CE_4), .cyc1MHz(cyc1MHz),
    .crtc_ma(crtc_ma), .crtc_ra(crtc_ra), .crtc_de(crtc_de),
    .vram_D(vram_D), .vram_valid(vram_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_overrun(mem_overrun)
  );
  amstrad_vram_sched #(.FETCH_WHEN_BLANK(1'b0)) u_blank (
    .CLK(CLK), .RESET(RESET), .CE_4(CE_4), .cyc1MHz(b_cyc),
    .crtc_ma(crtc_ma), .crtc_ra(crtc_ra), .crtc_de(crtc_de),
    .vram_D(b_vram), .vram_valid(b_valid),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'h0000), .cpu_dout(8'h00),
    .cpu_din(b_din), .cpu_ack(b_cack), .cpu_wait(b_wait),
    .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd),
    .mem_rdata(b_rdata), .mem_ack(b_ack), .mem_overrun(b_ovr)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK)
    if (RESET) begin
      ce_n    <= 0;
      ce_edge <= 1'b0;
    end else begin
      ce_edge <= CE_4;
      if (CE_4) ce_n <= ce_n + 1;
    end
  initial forever begin
    repeat (3) @(negedge CLK);
    CE_4 = 1'b1;
    @(negedge CLK);
    CE_4 = 1'b0;
  end
  // RAM model: acks 2 clocks after a request is first seen, unless hold withholds it.
  initial forever begin
    @(negedge CLK);
    mem_ack = 1'b0;
    if (RESET || !mem_req || hold) cnt = 0;
    else begin
      cnt = cnt + 1;
      if (cnt == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        last_addr = mem_addr;
        last_we   = mem_we;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wr_n = wr_n + 1;
        end
        cnt = 0;
      end
    end
  end
  initial forever begin
    @(negedge CLK);
    b_ack = 1'b0;
    if (RESET || !b_req) bcnt = 0;
    else begin
      bcnt = bcnt + 1;
      if (bcnt == 2) begin
        b_ack   = 1'b1;
        b_rdata = b_addr[7:0] ^ 8'h5A;
        bcnt    = 0;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_ph(input int p);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      ok = ce_edge && (ce_n % 4 == p);
    end
    if (!ok) chk("wait_ph", 0, 1);
  endtask
  task automatic wait_ack(output int ph, output int us);
    bit ok = 1'b0;
    ph = -1;
    us = -1;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge CLK);
      if (cpu_ack) begin
        ok = 1'b1;
        ph = ce_n % 4;
        us = ce_n / 4;
      end
    end
    chk("ack_seen", ok, 1);
  endtask
  task automatic cpu_go(input bit we, input logic [15:0] a, input logic [7:0] d);
    cpu_we   = we;
    cpu_addr = a;
    cpu_dout = d;
    cpu_req  = 1'b1;
  endtask

  initial begin
    int ph, us, ph2, us2, w0, n;
    bit ok;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
    mem[16'hD000] = 8'h11;
    mem[16'hD001] = 8'h22;
    mem[16'h4000] = 8'h5A;
    mem[16'h6000] = 8'h00;
    mem[16'h7000] = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_main", {cyc1MHz, vram_D, vram_valid, cpu_din, cpu_ack, cpu_wait, mem_req, mem_we,
                     mem_addr, mem_wdata, mem_overrun}, 0);
    chk("rst_blank", {b_cyc, b_vram, b_valid, b_din, b_cack, b_wait, b_req, b_we, b_addr, b_wd, b_ovr}, 0);
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("cyc1mhz", cyc1MHz, ce_n % 4 == 0);
    end
    wait_ph(3);
    crtc_ma = 14'h3000;
    crtc_ra = 5'd2;
    wait_ph(0);
    chk("vid_even", {mem_req, mem_we, mem_addr}, {2'b10, 16'hD000});
    wait_ph(1);
    chk("vid_odd", {mem_req, mem_we, mem_addr}, {2'b10, 16'hD001});
    wait_ph(2);
    chk("vid_valid", vram_valid, 1);
    chk("vid_D", vram_D, 16'h2211);
    @(negedge CLK);
    chk("vid_pulse", vram_valid, 0);
    chk("no_ovr", mem_overrun, 0);
    wait_ph(0);
    cpu_go(1'b0, 16'h4000, 8'h00);
    @(negedge CLK);
    chk("rd_wait", cpu_wait, 1);
    wait_ack(ph, us);
    chk("rd_ack_ph", ph, 2);
    chk("rd_din", cpu_din, 8'h5A);
    chk("rd_addr", {last_we, last_addr}, {1'b0, 16'h4000});
    chk("rd_wait_ack", cpu_wait, 1);
    cpu_req = 1'b0;
    @(negedge CLK);
    chk("rd_ack_pulse", cpu_ack, 0);
    chk("rd_wait_clr", cpu_wait, 0);
    wait_ph(3);
    crtc_de = 1'b0;
    crtc_ma = 14'h0123;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (b_req) n++;
      ok = ce_edge && (ce_n % 4 == 2);
    end
    chk("blk_reach", ok, 1);
    chk("blk_noreq", n, 0);
    chk("blk_valid", b_valid, 1);
    chk("blk_hold", b_vram, 16'h5B5A);
    crtc_de = 1'b1;
    wait_ph(0);
    cpu_go(1'b1, 16'h6000, 8'h77);
    w0 = wr_n;
    wait_ph(1);
    repeat (3) @(negedge CLK);
    hold = 1'b1;
    wait_ph(3);
    chk("ovr_flag", mem_overrun, 1);
    chk("ovr_nowr", wr_n - w0, 0);
    chk("ovr_wait", cpu_wait, 1);
    hold = 1'b0;
    wait_ack(ph, us);
    chk("ovr_retry_ph", ph, RETRY_PH);
    chk("ovr_once", wr_n - w0, 1);
    chk("ovr_mem", mem[16'h6000], 8'h77);
    cpu_req = 1'b0;
    wait_ph(0);
    cpu_go(1'b1, 16'h5000, 8'hA1);
    wait_ack(ph, us);
    cpu_go(1'b1, 16'h5001, 8'hA2);
    wait_ack(ph2, us2);
    cpu_req = 1'b0;
    chk("t_ack1_ph", ph, 2);
    chk("t_ack2_ph", ph2, T2_PH);
    chk("t_ack2_us", us2 - us, T2_DUS);
    chk("t_mem", {mem[16'h5000], mem[16'h5001]}, 16'hA1A2);
    wait_ph(0);
    cpu_go(1'b1, 16'h7000, 8'h99);
    w0 = wr_n;
    wait_ph(2);
    chk("ar_busy", {mem_req, mem_we}, 2'b11);
    #1 RESET = 1'b1;
    #1 chk("ar_out", {cyc1MHz, vram_D, vram_valid, cpu_din, cpu_ack, cpu_wait, mem_req, mem_we,
                      mem_addr, mem_wdata, mem_overrun}, 0);
    cpu_req = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (cpu_ack) n++;
    end
    chk("ar_noack", n, 0);
    chk("ar_nowr", wr_n - w0, 0);
    chk("ar_mem", mem[16'h7000], 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
